mandel_scan_engine: RTL

Parametrised successor to the single-iterator raster loop. Scans an X_PIX × Y_PIX grid of complex points and farms pixels round-robin across N_ENGINES parallel Mandelbrot iterator instances. Results are returned in raster order through a valid/ready stream, with a per-frame iteration total. Sits between the frame-config registers and the pixel colour-map/VGA write path.

---
 rtl/mandel_pkg.sv | 35 +++
 rtl/mandel_iter.sv | 105 ++++++++++
 rtl/mandel_scan_engine.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mandel_pkg.sv
// Shared types and fixed-point helpers for the Mandelbrot scan engine and its iterators.
package mandel_pkg;

    // Width of the result-struct fields; covers grids up to 65536 wide/high and ITER_W <= 16.
    localparam int FIELD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [FIELD_W-1:0] col;
        logic [FIELD_W-1:0] row;
        logic [FIELD_W-1:0] count;
    } px_res_t;

    function automatic logic signed [63:0] escape_scaled(input int frac);
        return 64'sd4 <<< frac;
    endfunction

    function automatic logic signed [63:0] mul_full(input logic signed [63:0] a,
                                                    input logic signed [63:0] b);
        return a * b;
    endfunction

    // Drops the low frac bits of a full product; caller keeps the low COORD_W bits.
    function automatic logic signed [63:0] mul_trunc(input logic signed [63:0] p,
                                                     input int frac);
        return p >>> frac;
    endfunction

endpackage

// File: rtl/mandel_iter.sv
// Single Mandelbrot iterator: holds the full-precision squares of the current z so the
// next z and its escape magnitude are produced in one cycle.
module mandel_iter
    import mandel_pkg::*;
#(
    parameter int COORD_W = 27,
    parameter int FRAC_W  = 23,
    parameter int ITER_W  = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [COORD_W-1:0] cr_i,
    input  logic [COORD_W-1:0] ci_i,
    input  logic [ITER_W-1:0]  max_iter_i,
    input  logic               clear_i,
    output logic               busy_o,
    output logic               finished_o,
    output logic [ITER_W-1:0]  count_o
);

    localparam logic signed [63:0] ESCAPE = escape_scaled(2 * FRAC_W);

    logic                      run_q, run_d, fin_q, fin_d;
    logic [ITER_W-1:0]         count_q, count_d, count_n;
    logic [COORD_W-1:0]        cr_q, cr_d, ci_q, ci_d;
    logic signed [63:0]        prr_q, prr_d, pii_q, pii_d, pri_q, pri_d;
    logic signed [63:0]        prr_n, pii_n, pri_n, mag_n;
    logic signed [COORD_W-1:0] t_rr, t_ii, t_ri, zr_n, zi_n;

    // Iteration datapath and stop/hold control
    always_comb begin
        run_d   = run_q;
        fin_d   = fin_q;
        count_d = count_q;
        cr_d    = cr_q;
        ci_d    = ci_q;
        prr_d   = prr_q;
        pii_d   = pii_q;
        pri_d   = pri_q;
        t_rr    = COORD_W'(mul_trunc(prr_q, FRAC_W));
        t_ii    = COORD_W'(mul_trunc(pii_q, FRAC_W));
        t_ri    = COORD_W'(mul_trunc(pri_q, FRAC_W));
        zr_n    = t_rr - t_ii + cr_q;
        zi_n    = (t_ri <<< 1) + ci_q;
        prr_n   = mul_full(64'(zr_n), 64'(zr_n));
        pii_n   = mul_full(64'(zi_n), 64'(zi_n));
        pri_n   = mul_full(64'(zr_n), 64'(zi_n));
        mag_n   = prr_n + pii_n;
        count_n = count_q + ITER_W'(1);
        if (start_i) begin
            run_d   = 1'b1;
            fin_d   = 1'b0;
            count_d = '0;
            cr_d    = cr_i;
            ci_d    = ci_i;
            prr_d   = '0;
            pii_d   = '0;
            pri_d   = '0;
        end else if (run_q) begin
            count_d = count_n;
            prr_d   = prr_n;
            pii_d   = pii_n;
            pri_d   = pri_n;
            if ((mag_n > ESCAPE) || (count_n == max_iter_i)) begin
                run_d = 1'b0;
                fin_d = 1'b1;
            end else begin
                run_d = 1'b1;
            end
        end else if (clear_i) begin
            fin_d = 1'b0;
        end else begin
            fin_d = fin_q;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            run_q   <= 1'b0;
            fin_q   <= 1'b0;
            count_q <= '0;
            cr_q    <= '0;
            ci_q    <= '0;
            prr_q   <= '0;
            pii_q   <= '0;
            pri_q   <= '0;
        end else begin
            run_q   <= run_d;
            fin_q   <= fin_d;
            count_q <= count_d;
            cr_q    <= cr_d;
            ci_q    <= ci_d;
            prr_q   <= prr_d;
            pii_q   <= pii_d;
            pri_q   <= pri_d;
        end
    end

    assign busy_o     = run_q | fin_q;
    assign finished_o = fin_q;
    assign count_o    = count_q;

endmodule

// File: rtl/mandel_scan_engine.sv
// Raster scan of a complex grid farmed round-robin over N_ENGINES iterators; results return
// in raster order through a one-deep valid/ready output register with a per-frame total.
module mandel_scan_engine
    import mandel_pkg::*;
#(
    parameter int N_ENGINES = 4,
    parameter int COORD_W   = 27,
    parameter int FRAC_W    = 23,
    parameter int ITER_W    = 11,
    parameter int X_PIX     = 640,
    parameter int Y_PIX     = 480
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic [COORD_W-1:0]                            init_x,
    input  logic [COORD_W-1:0]                            init_y,
    input  logic [COORD_W-1:0]                            x_incr,
    input  logic [COORD_W-1:0]                            y_incr,
    input  logic [ITER_W-1:0]                             max_iter,
    output logic                                          px_valid,
    input  logic                                          px_ready,
    output logic [$clog2((X_PIX > 1) ? X_PIX : 2)-1:0]    px_col,
    output logic [$clog2((Y_PIX > 1) ? Y_PIX : 2)-1:0]    px_row,
    output logic [ITER_W-1:0]                             px_count,
    output logic [31:0]                                   total_counter,
    output logic                                          busy,
    output logic                                          done
);

    localparam int COL_W = $clog2((X_PIX > 1) ? X_PIX : 2);
    localparam int ROW_W = $clog2((Y_PIX > 1) ? Y_PIX : 2);
    localparam int PTR_W = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;

    state_e             state_q, state_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [COORD_W-1:0] init_x_q, init_x_d, x_incr_q, x_incr_d, y_incr_q, y_incr_d;
    logic [ITER_W-1:0]  max_iter_q, max_iter_d;
    logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [COL_W-1:0]   col_q, col_d, ccol_q, ccol_d;
    logic [ROW_W-1:0]   row_q, row_d, crow_q, crow_d;
    logic [PTR_W-1:0]   d_ptr_q, d_ptr_d, c_ptr_q, c_ptr_d;
    px_res_t            px_q, px_d;
    logic               px_valid_q, px_valid_d;
    logic [31:0]        total_q, total_d;

    logic [N_ENGINES-1:0] eng_start, eng_clear, eng_busy, eng_fin;
    logic [ITER_W-1:0]    eng_count [N_ENGINES];
    logic                 accept_s, collect_s, last_out_s;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_ENGINES - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    for (genvar g = 0; g < N_ENGINES; g++) begin : g_eng
        mandel_iter #(
            .COORD_W (COORD_W),
            .FRAC_W  (FRAC_W),
            .ITER_W  (ITER_W)
        ) u_iter (
            .clk        (clk),
            .reset      (reset),
            .start_i    (eng_start[g]),
            .cr_i       (cur_x_q),
            .ci_i       (cur_y_q),
            .max_iter_i (max_iter_q),
            .clear_i    (eng_clear[g]),
            .busy_o     (eng_busy[g]),
            .finished_o (eng_fin[g]),
            .count_o    (eng_count[g])
        );
    end

    // Frame FSM, dispatcher, collector and output register next-state
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = done_q;
        init_x_d   = init_x_q;
        x_incr_d   = x_incr_q;
        y_incr_d   = y_incr_q;
        max_iter_d = max_iter_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        col_d      = col_q;
        row_d      = row_q;
        ccol_d     = ccol_q;
        crow_d     = crow_q;
        d_ptr_d    = d_ptr_q;
        c_ptr_d    = c_ptr_q;
        px_d       = px_q;
        px_valid_d = px_valid_q;
        total_d    = total_q;
        eng_start  = '0;
        eng_clear  = '0;
        accept_s   = px_valid_q && px_ready;
        collect_s  = eng_fin[c_ptr_q] && (!px_valid_q || px_ready);
        last_out_s = (px_q.col == FIELD_W'(X_PIX - 1)) && (px_q.row == FIELD_W'(Y_PIX - 1));

        if (accept_s) begin
            total_d = total_q + 32'(px_q.count);
        end else begin
            total_d = total_q;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RUN;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    total_d    = '0;
                    init_x_d   = init_x;
                    x_incr_d   = x_incr;
                    y_incr_d   = y_incr;
                    max_iter_d = (max_iter == '0) ? ITER_W'(1) : max_iter;
                    cur_x_d    = init_x;
                    cur_y_d    = init_y;
                    col_d      = '0;
                    row_d      = '0;
                    ccol_d     = '0;
                    crow_d     = '0;
                    d_ptr_d    = '0;
                    c_ptr_d    = '0;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                if (!eng_busy[d_ptr_q]) begin
                    eng_start[d_ptr_q] = 1'b1;
                    d_ptr_d            = ptr_next(d_ptr_q);
                    if (col_q == COL_W'(X_PIX - 1)) begin
                        col_d   = '0;
                        cur_x_d = init_x_q;
                        row_d   = row_q + ROW_W'(1);
                        cur_y_d = cur_y_q + y_incr_q;
                        if (row_q == ROW_W'(Y_PIX - 1)) begin
                            state_d = DRAIN;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        col_d   = col_q + COL_W'(1);
                        cur_x_d = cur_x_q + x_incr_q;
                    end
                end else begin
                    d_ptr_d = d_ptr_q;
                end
            end
            DRAIN: begin
                if (accept_s && last_out_s) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Collection follows dispatch order, so the output stream is in raster order
        if (collect_s) begin
            px_valid_d         = 1'b1;
            px_d.col           = FIELD_W'(ccol_q);
            px_d.row           = FIELD_W'(crow_q);
            px_d.count         = FIELD_W'(eng_count[c_ptr_q]);
            eng_clear[c_ptr_q] = 1'b1;
            c_ptr_d            = ptr_next(c_ptr_q);
            if (ccol_q == COL_W'(X_PIX - 1)) begin
                ccol_d = '0;
                crow_d = crow_q + ROW_W'(1);
            end else begin
                ccol_d = ccol_q + COL_W'(1);
            end
        end else if (accept_s) begin
            px_valid_d = 1'b0;
        end else begin
            px_valid_d = px_valid_q;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            init_x_q   <= '0;
            x_incr_q   <= '0;
            y_incr_q   <= '0;
            max_iter_q <= ITER_W'(1);
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            ccol_q     <= '0;
            crow_q     <= '0;
            d_ptr_q    <= '0;
            c_ptr_q    <= '0;
            px_q       <= '0;
            px_valid_q <= 1'b0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            init_x_q   <= init_x_d;
            x_incr_q   <= x_incr_d;
            y_incr_q   <= y_incr_d;
            max_iter_q <= max_iter_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            col_q      <= col_d;
            row_q      <= row_d;
            ccol_q     <= ccol_d;
            crow_q     <= crow_d;
            d_ptr_q    <= d_ptr_d;
            c_ptr_q    <= c_ptr_d;
            px_q       <= px_d;
            px_valid_q <= px_valid_d;
            total_q    <= total_d;
        end
    end

    assign px_valid      = px_valid_q;
    assign px_col        = px_q.col[COL_W-1:0];
    assign px_row        = px_q.row[ROW_W-1:0];
    assign px_count      = px_q.count[ITER_W-1:0];
    assign total_counter = total_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
